// File: rtl/lap_bank.sv
// rtl/lap_bank.sv - circular lap snapshot store with newest-first recall for the stopwatch display
// Optional LAP_OVERWRITE_EN: a capture while full replaces the oldest lap instead of being dropped.
module lap_bank #(
  parameter  int NDIG  = 6,
  parameter  int DW    = 7,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int WW    = NDIG * DW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lap_btn,
  input  logic          view_btn,
  input  logic          clr,
  input  logic [WW-1:0] cur_in,
  output logic [WW-1:0] disp_out,
  output logic [CW-1:0] count,
  output logic [CW-1:0] view_idx,
  output logic          full,
  output logic          ovf
);

`ifdef LAP_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  logic          lap_q, view_q;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] vidx_q, vidx_d;
  logic          ovf_q, ovf_d;
  logic          live_q;
  logic [WW-1:0] rd_q;
  logic [WW-1:0] mem_q [DEPTH];
  logic          we;
  logic          lap_p, view_p, full_w;
  logic [AW-1:0] rd_addr;

  assign lap_p  = lap_btn & ~lap_q;
  assign view_p = view_btn & ~view_q;
  assign full_w = (count_q == CW'(DEPTH));

  // view_idx == DEPTH wraps to wp itself, which is the oldest slot when full
  assign rd_addr = wp_q - vidx_q[AW-1:0];

  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    vidx_d  = vidx_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    if (clr) begin
      wp_d    = '0;
      count_d = '0;
      vidx_d  = '0;
      ovf_d   = 1'b0;
    end else if (lap_p) begin
      vidx_d = '0;
      if (!full_w || OVERWRITE) begin
        we   = 1'b1;
        wp_d = wp_q + AW'(1);
        if (!full_w) begin
          count_d = count_q + CW'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (view_p && (count_q != '0)) begin
      vidx_d = (vidx_q == count_q) ? '0 : vidx_q + CW'(1);
    end
  end

  // Button history loads even in reset so a button held through reset gives no pulse
  always_ff @(posedge clk) begin
    lap_q  <= lap_btn;
    view_q <= view_btn;
    if (!rst_n) begin
      wp_q    <= '0;
      count_q <= '0;
      vidx_q  <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b1;
      rd_q    <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      vidx_q  <= vidx_d;
      ovf_q   <= ovf_d;
      live_q  <= (vidx_q == '0);
      rd_q    <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wp_q] <= cur_in;
    end
  end

  assign disp_out = live_q ? cur_in : rd_q;
  assign count    = count_q;
  assign view_idx = vidx_q;
  assign full     = full_w;
  assign ovf      = ovf_q;

endmodule
